// File: rtl/ast_fifo_rl.sv
// Avalon-ST single-clock FIFO. The sink side honours a ready latency of
// 0..4 cycles and the source side uses ready latency 0. It stores packet
// sideband and reports fill level, stored-packet count and a sticky overflow.
module ast_fifo_rl #(
    parameter int DATABITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_BEAT    = 4,
    parameter int DEPTH               = 16,
    parameter int READY_LATENCY       = 2,
    parameter int USE_PACKETS         = 1,
    parameter int EMPTY_W             = (SYMBOLS_PER_BEAT > 1) ? $clog2(SYMBOLS_PER_BEAT) : 1
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] snk_data_i,
    input  logic                                           snk_valid_i,
    input  logic                                           snk_startofpacket_i,
    input  logic                                           snk_endofpacket_i,
    input  logic [EMPTY_W-1:0]                             snk_empty_i,
    output logic                                           snk_ready_o,
    output logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] src_data_o,
    output logic                                           src_valid_o,
    output logic                                           src_startofpacket_o,
    output logic                                           src_endofpacket_o,
    output logic [EMPTY_W-1:0]                             src_empty_o,
    input  logic                                           src_ready_i,
    output logic [$clog2(DEPTH):0]                         fill_level_o,
    output logic [$clog2(DEPTH):0]                         pkt_count_o,
    output logic                                           overflow_o
);

    localparam int DATA_W  = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_W + 2 + EMPTY_W;
    localparam int PIPE_W  = (READY_LATENCY > 0) ? READY_LATENCY : 1;
    localparam int EOP_BIT = DATA_W + EMPTY_W;
    localparam int SOP_BIT = DATA_W + EMPTY_W + 1;
    localparam logic [AW:0] ONE       = (AW+1)'(1);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 1 - READY_LATENCY);

    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]         fill_q, fill_d;
    logic [AW:0]         pkt_q, pkt_d;
    logic [PIPE_W-1:0]   rdy_pipe_q, rdy_pipe_d;
    logic                ovf_q, ovf_d;
    logic                ready_en_q;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];

    logic                full, empty, credit, wr_en, rd_en;
    logic                wr_eop, rd_eop;
    logic [ENTRY_W-1:0]  wr_entry, head;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head   = mem_q[rd_ptr_q[AW-1:0]];

    // Ready stays low until the first edge after reset release; afterwards
    // the threshold keeps READY_LATENCY slots free for beats already granted.
    assign snk_ready_o = ready_en_q && (fill_q <= READY_MAX);

    // With zero latency the current ready is the credit; otherwise the
    // oldest stage of the ready history grants this cycle's beat.
    assign credit = (READY_LATENCY == 0) ? snk_ready_o : rdy_pipe_q[PIPE_W-1];

    assign rd_en  = !empty && src_ready_i;
    // A credited beat at full is only taken when a read frees the slot.
    assign wr_en  = snk_valid_i && credit && (!full || rd_en);
    assign wr_eop = wr_en && wr_entry[EOP_BIT];
    assign rd_eop = rd_en && head[EOP_BIT];

    // Build the stored entry; sideband is zeroed when packets are disabled.
    always_comb begin
        wr_entry = '0;
        wr_entry[DATA_W-1:0] = snk_data_i;
        if (USE_PACKETS != 0) begin
            wr_entry[DATA_W +: EMPTY_W] = snk_empty_i;
            wr_entry[EOP_BIT]           = snk_endofpacket_i;
            wr_entry[SOP_BIT]           = snk_startofpacket_i;
        end
    end

    // Next-state for pointers, counters, ready history and overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        pkt_d    = pkt_q;
        ovf_d    = ovf_q || (snk_valid_i && !wr_en);
        if (wr_en) wr_ptr_d = wr_ptr_q + ONE;
        if (rd_en) rd_ptr_d = rd_ptr_q + ONE;
        if (wr_en && !rd_en) fill_d = fill_q + ONE;
        else if (!wr_en && rd_en) fill_d = fill_q - ONE;
        if (wr_eop && !rd_eop) pkt_d = pkt_q + ONE;
        else if (!wr_eop && rd_eop) pkt_d = pkt_q - ONE;
        rdy_pipe_d    = '0;
        rdy_pipe_d[0] = snk_ready_o;
        for (int unsigned i = 1; i < PIPE_W; i++) begin
            rdy_pipe_d[i] = rdy_pipe_q[i-1];
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            pkt_q      <= '0;
            rdy_pipe_q <= '0;
            ovf_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            pkt_q      <= pkt_d;
            rdy_pipe_q <= rdy_pipe_d;
            ovf_q      <= ovf_d;
            ready_en_q <= 1'b1;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end

    // Show-ahead source outputs, forced to zero while nothing is stored.
    assign src_valid_o         = !empty;
    assign src_data_o          = src_valid_o ? head[DATA_W-1:0]       : '0;
    assign src_empty_o         = src_valid_o ? head[DATA_W +: EMPTY_W] : '0;
    assign src_endofpacket_o   = src_valid_o && head[EOP_BIT];
    assign src_startofpacket_o = src_valid_o && head[SOP_BIT];

    assign fill_level_o = fill_q;
    assign pkt_count_o  = (USE_PACKETS != 0) ? pkt_q : '0;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_ast_fifo_rl.sv
// Bench for ast_fifo_rl: a DEPTH=16 / RL=2 packet build checked through a
// scoreboard, plus an RL=0 build without packets checked with direct vectors.
module tb_ast_fifo_rl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [31:0] snk_data;  logic snk_valid, snk_sop, snk_eop; logic [1:0] snk_empty; logic snk_ready;
    logic [31:0] src_data;  logic src_valid, src_sop, src_eop; logic [1:0] src_empty; logic src_ready;
    logic [4:0]  fill, pkt; logic ovf;

    logic [31:0] b_snk_data; logic b_snk_valid, b_snk_sop, b_snk_eop; logic [1:0] b_snk_empty; logic b_snk_ready;
    logic [31:0] b_src_data; logic b_src_valid, b_src_sop, b_src_eop; logic [1:0] b_src_empty; logic b_src_ready;
    logic [4:0]  b_fill, b_pkt; logic b_ovf;

    always #5 clk = ~clk;

    ast_fifo_rl #(.DATABITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(4), .DEPTH(16),
                  .READY_LATENCY(2), .USE_PACKETS(1)) dut_a (
        .clk_i(clk), .rst_i(rst_n),
        .snk_data_i(snk_data), .snk_valid_i(snk_valid), .snk_startofpacket_i(snk_sop),
        .snk_endofpacket_i(snk_eop), .snk_empty_i(snk_empty), .snk_ready_o(snk_ready),
        .src_data_o(src_data), .src_valid_o(src_valid), .src_startofpacket_o(src_sop),
        .src_endofpacket_o(src_eop), .src_empty_o(src_empty), .src_ready_i(src_ready),
        .fill_level_o(fill), .pkt_count_o(pkt), .overflow_o(ovf));

    ast_fifo_rl #(.DATABITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(4), .DEPTH(16),
                  .READY_LATENCY(0), .USE_PACKETS(0)) dut_b (
        .clk_i(clk), .rst_i(rst_n),
        .snk_data_i(b_snk_data), .snk_valid_i(b_snk_valid), .snk_startofpacket_i(b_snk_sop),
        .snk_endofpacket_i(b_snk_eop), .snk_empty_i(b_snk_empty), .snk_ready_o(b_snk_ready),
        .src_data_o(b_src_data), .src_valid_o(b_src_valid), .src_startofpacket_o(b_src_sop),
        .src_endofpacket_o(b_src_eop), .src_empty_o(b_src_empty), .src_ready_i(b_src_ready),
        .fill_level_o(b_fill), .pkt_count_o(b_pkt), .overflow_o(b_ovf));

    int n_checks = 0;
    int n_fail   = 0;

    // Expected beats {sop, eop, empty[1:0], data[31:0]} in acceptance order.
    logic [35:0] sb_q[$];

    // Reference model of the RL=2 build.
    int          exp_fill = 0;
    int          exp_pkt  = 0;
    bit          exp_ovf  = 1'b0;
    bit          mr1 = 1'b0, mr2 = 1'b0;
    logic [31:0] next_data;
    bit          sent_flag;
    int          b_cnt;
    logic [35:0] pkt_beats [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted source beat is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && src_valid && src_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h expected none", src_data);
            end else begin
                chk("src_beat", {src_sop, src_eop, src_empty, src_data}, sb_q.pop_front());
            end
        end
    end

    // One cycle on the RL=2 build: drive, check status mid-cycle, advance model.
    task automatic step(input bit send_req, input bit force_bad, input logic [35:0] beat,
                        output bit sent);
        bit rd, rd_eop, ready_m;
        sent      = send_req && mr2;
        snk_valid = sent || force_bad;
        if (force_bad && !sent) {snk_sop, snk_eop, snk_empty, snk_data} = {4'b0, 32'hDEADBEEF};
        else                    {snk_sop, snk_eop, snk_empty, snk_data} = beat;
        if (sent) sb_q.push_back(beat);
        rd     = src_ready && (exp_fill > 0);
        rd_eop = 1'b0;
        if (rd) rd_eop = sb_q[0][34];
        ready_m = (exp_fill <= 13);
        @(negedge clk);
        chk("fill_level", fill, exp_fill);
        chk("snk_ready", snk_ready, ready_m);
        chk("pkt_count", pkt, exp_pkt);
        chk("overflow", ovf, exp_ovf);
        @(posedge clk); #1;
        if (force_bad && !mr2) exp_ovf = 1'b1;
        exp_fill = exp_fill + int'(sent) - int'(rd);
        exp_pkt  = exp_pkt + int'(sent && beat[34]) - int'(rd_eop);
        mr2 = mr1;
        mr1 = ready_m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        {snk_data, snk_valid, snk_sop, snk_eop, snk_empty, src_ready} = '0;
        {b_snk_data, b_snk_valid, b_snk_sop, b_snk_eop, b_snk_empty, b_src_ready} = '0;
        pkt_beats[0] = {1'b1, 1'b0, 2'd0, 32'h000000A0};
        pkt_beats[1] = {1'b0, 1'b0, 2'd0, 32'h000000A1};
        pkt_beats[2] = {1'b0, 1'b1, 2'd2, 32'h000000A2};
        pkt_beats[3] = {1'b1, 1'b1, 2'd0, 32'h000000B0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_snk_ready", snk_ready, 0);
        chk("rst_src_valid", src_valid, 0);
        chk("rst_fill", fill, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_b_snk_ready", b_snk_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_snk_ready", snk_ready, 1);
        chk("rel_src_valid", src_valid, 0);

        // Stream 20 beats on credit with the consumer stalled: 16 fit.
        next_data = 32'h0;
        for (int c = 0; c < 30; c++) begin
            step(next_data < 20, 1'b0, {4'b0, next_data}, sent_flag);
            if (sent_flag) next_data++;
        end
        chk("stream_fill16", fill, 16);
        chk("stream_no_ovf", ovf, 0);
        chk("stream_accepted", next_data, 16);

        // Uncredited beat while ready has been low for three cycles.
        repeat (3) step(1'b0, 1'b0, '0, sent_flag);
        step(1'b0, 1'b1, '0, sent_flag);
        repeat (3) step(1'b0, 1'b0, '0, sent_flag);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_fill", fill, 16);

        // Consumer always ready, producer on every credit across pointer wraps.
        src_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step(1'b1, 1'b0, {4'b0, next_data}, sent_flag);
            if (sent_flag) next_data++;
        end
        for (int c = 0; c < 40 && exp_fill > 0; c++) step(1'b0, 1'b0, '0, sent_flag);
        chk("drain_done", exp_fill, 0);
        chk("drain_sb_empty", sb_q.size(), 0);
        chk("drain_src_valid", src_valid, 0);

        // Packets: 3-beat packet then a single-beat packet.
        src_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sent_flag = 1'b0;
            for (int c = 0; c < 8 && !sent_flag; c++) step(1'b1, 1'b0, pkt_beats[k], sent_flag);
            chk("pkt_beat_sent", sent_flag, 1);
        end
        repeat (2) step(1'b0, 1'b0, '0, sent_flag);
        chk("pkt_count2", pkt, 2);
        src_ready = 1'b1;
        for (int c = 0; c < 10 && exp_fill > 0; c++) step(1'b0, 1'b0, '0, sent_flag);
        chk("pkt_drained", pkt, 0);
        src_ready = 1'b0;
        snk_valid = 1'b0;

        // RL=0 build without packet storage.
        b_snk_sop = 1'b1; b_snk_eop = 1'b1; b_snk_empty = 2'd3;
        b_snk_valid = 1'b1; b_snk_data = 32'h100;
        @(negedge clk);
        chk("b_no_fallthrough", b_src_valid, 0);
        chk("b_ready_empty", b_snk_ready, 1);
        @(posedge clk); #1;
        b_snk_valid = 1'b0;
        @(negedge clk);
        chk("b_valid_next", b_src_valid, 1);
        chk("b_first_data", b_src_data, 32'h100);
        chk("b_fill1", b_fill, 1);
        b_cnt = 1;
        for (int i = 0; i < 18; i++) begin
            bit wr;
            @(posedge clk); #1;
            wr = (b_cnt < 16);
            b_snk_valid = wr;
            b_snk_data  = 32'h100 + b_cnt;
            @(negedge clk);
            chk("b_fill", b_fill, b_cnt);
            chk("b_ready", b_snk_ready, b_cnt != 16);
            if (wr) b_cnt++;
        end
        @(posedge clk); #1;
        b_snk_valid = 1'b1; b_snk_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        b_snk_valid = 1'b0;
        chk("b_ovf", b_ovf, 1);
        chk("b_fill_full", b_fill, 16);
        chk("b_sideband_zero", {b_src_sop, b_src_eop, b_src_empty}, 0);
        chk("b_pkt_zero", b_pkt, 0);
        b_src_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("b_drain_data", b_src_data, 32'h100 + k);
            @(posedge clk); #1;
        end
        b_src_ready = 1'b0;
        chk("b_empty_after", b_src_valid, 0);

        // Asynchronous reset with seven beats stored.
        for (int c = 0; c < 20 && exp_fill < 7; c++) begin
            step(1'b1, 1'b0, {4'b0, next_data}, sent_flag);
            if (sent_flag) next_data++;
        end
        snk_valid = 1'b0;
        chk("pre_rst_fill7", fill, 7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_src_valid", src_valid, 0);
        chk("arst_snk_ready", snk_ready, 0);
        chk("arst_fill", fill, 0);
        chk("arst_pkt", pkt, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_src_fields", {src_sop, src_eop, src_empty, src_data}, 0);
        chk("arst_b_ovf", b_ovf, 0);
        sb_q.delete();
        exp_fill = 0; exp_pkt = 0; exp_ovf = 1'b0; mr1 = 1'b0; mr2 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", snk_ready, 1);
        chk("post_rst_valid", src_valid, 0);
        chk("post_rst_fill", fill, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
